// File: rtl/arbiter_8_rr.sv
// arbiter_8_rr: 8-way round-robin arbiter with a per-grant hold limit.
// A granted requester keeps the grant until it drops its request, en drops,
// or it has held the grant for HOLD_MAX cycles. After each release there is
// a one-cycle GAP, then IDLE, before the next grant is issued.
module arbiter_8_rr #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_e;

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       expired_q, expired_d;

  logic       win_found;
  logic [2:0] win_id;
  logic [2:0] scan_idx;
  logic       release_now;

  // Round-robin search: first set request starting at ptr, wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Any one of these ends the current grant.
  always_comb begin
    release_now = !req[gnt_id_q] || !en || (hold_cnt_q >= HOLD_LIMIT);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    expired_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          state_d     = BUSY;
          gnt_d       = 8'(1) << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d     = GAP;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = gnt_id_q + 3'd1;
          // Request still present and enabled: the limit alone ended it.
          expired_d   = req[gnt_id_q] && en;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      expired_q   <= expired_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_arbiter_8_rr.sv
// Scoreboard bench for arbiter_8_rr with HOLD_MAX=4.
module tb_arbiter_8_rr;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       expired;

  arbiter_8_rr #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the grant, how long, whether a cool-down cycle
  // is pending, and where the next search begins.
  int owner = -1;
  int held  = 0;
  int start = 0;
  bit gap_pending = 0;
  bit exp_pulse   = 0;

  function automatic void model_reset();
    owner = -1; held = 0; start = 0; gap_pending = 0; exp_pulse = 0;
  endfunction

  function automatic void model_step(input logic e_in, input logic [7:0] r);
    exp_pulse = 0;
    if (owner >= 0) begin
      if (!r[owner] || !e_in || held == HM) begin
        exp_pulse   = r[owner] && e_in;
        start       = (owner + 1) % 8;
        owner       = -1;
        gap_pending = 1;
      end else begin
        held++;
      end
    end else if (gap_pending) begin
      gap_pending = 0;
    end else if (e_in && r != 0) begin
      for (int k = 0; k < 8; k++)
        if (owner < 0 && r[(start + k) % 8]) owner = (start + k) % 8;
      held = 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t o;
    o.gnt = (owner >= 0) ? (8'(1) << owner) : 8'h00;
    o.id  = (owner >= 0) ? 3'(owner) : 3'd0;
    o.v   = (owner >= 0);
    o.e   = exp_pulse;
    return o;
  endfunction

  task automatic apply(input logic e_in, input logic [7:0] r);
    en  = e_in;
    req = r;
    model_step(e_in, r);
    sb_q.push_back(model_out());
  endtask

  task automatic drive(input logic e_in, input logic [7:0] r);
    @(negedge clk);
    apply(e_in, r);
  endtask

  task automatic drive_n(input logic e_in, input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) drive(e_in, r);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL %s @%0t: gnt=%b id=%0d valid=%b expired=%b, required all zero",
               name, $time, gnt, gnt_id, gnt_valid, expired);
    end
  endtask

  // Assert reset between edges, check the outputs clear at once, then
  // release it on a falling edge with the given inputs already applied.
  task automatic async_reset(input logic e_in, input logic [7:0] r);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(e_in, r);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (gnt !== x.gnt || gnt_id !== x.id || gnt_valid !== x.v || expired !== x.e) begin
          errors++;
          $display("FAIL grant @%0t: gnt=%b id=%0d valid=%b expired=%b, required gnt=%b id=%0d valid=%b expired=%b",
                   $time, gnt, gnt_id, gnt_valid, expired, x.gnt, x.id, x.v, x.e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;
    #2;
    check_zero("reset_state");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Single requester, one-cycle latency, hold limit, re-grant.
    apply(1'b1, 8'h01);
    drive_n(1'b1, 8'h01, 9);
    drive_n(1'b1, 8'h00, 3);

    // All requesting: full rotation with expiry pulses.
    async_reset(1'b1, 8'hFF);
    drive_n(1'b1, 8'hFF, 55);

    // Requester 4 wins from ptr 0, drops early; then 7.
    async_reset(1'b1, 8'h90);
    drive_n(1'b1, 8'h90, 2);
    drive_n(1'b1, 8'h80, 6);

    // Grant to 2 ended by en; nothing while en low; resumes from 3.
    async_reset(1'b1, 8'h04);
    drive_n(1'b1, 8'h04, 2);
    drive_n(1'b0, 8'hFF, 6);
    drive_n(1'b1, 8'hFF, 4);

    // Reset during grant to 5; restart from ptr 0 picks 0.
    async_reset(1'b1, 8'h20);
    drive_n(1'b1, 8'h20, 2);
    async_reset(1'b1, 8'h21);
    drive_n(1'b1, 8'h21, 3);

    // Enabled with no requests.
    drive_n(1'b1, 8'h00, 20);

    // Randomized traffic with sticky requests and occasional resets.
    r = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 299) == 0)
        async_reset($urandom_range(0, 9) != 0, r);
      else
        drive($urandom_range(0, 9) != 0, r);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
